sram_bank_sequencer: RTL
========================

Name: sram_bank_sequencer

Overview:
Initiator for the two-port SRAM bank. It takes one-at-a-time read/write requests from a simple valid/ready host interface. It drives Addr_A, Addr_B, din, ReadEn, RegWrtBar and WriteEn on the Bennett clock phases the bank requires. For reads it captures outA/outB and returns them on a response pulse.

Parameters:
WIDTH, 10, number of Bennett phases in clkpos
ADDR_W, 5, address width for port A and port B
DATA_W, 16, data width
PH_ADDR, 2, phase whose rise launches the addresses
PH_DATA, 4, phase whose rise launches write data
PH_EN, 6, phase whose rise asserts ReadEn or RegWrtBar
PH_WE, 8, phase whose rise asserts WriteEn (write) or ends ReadEn and samples data (read)
PH_WE_END, 9, phase whose rise deasserts WriteEn

Ports:
clk  in  1  system clock; the only clock. All logic is on its rising edge.
reset  in  1  asynchronous, active-high reset
clkpos  in  WIDTH  Bennett phase vector, sampled synchronously on clk
req_valid  in  1  host request valid
req_ready  out  1  high when IDLE
req_write  in  1  1 = write, 0 = read
req_addr_a  in  ADDR_W  port-A (write/read A) address
req_addr_b  in  ADDR_W  port-B read address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-clk pulse when a transaction completes
rsp_write  out  1  type of the completed transaction
rsp_data_a  out  DATA_W  captured outA
rsp_data_b  out  DATA_W  captured outB
Addr_A  out  ADDR_W  to bank
Addr_B  out  ADDR_W  to bank
din  out  DATA_W  to bank "in" bus
ReadEn  out  1  to bank
RegWrtBar  out  1  to bank
WriteEn  out  1  to bank
outA  in  DATA_W  from bank
outB  in  DATA_W  from bank

Behaviour:
- Reset: all outputs 0, except req_ready = 1. State = IDLE. clkpos_q = 0 and armed = 0.
- armed sets one clk after reset deasserts.
- Edge detection: rise[i] = clkpos[i] & ~clkpos_q[i] & armed; fall[i] = ~clkpos[i] & clkpos_q[i] & armed. No edges are seen during the first post-reset clk.
- Handshake: a request is accepted when req_valid & req_ready. All request fields are latched on acceptance. req_ready = (state==IDLE).
- FSM, one edge event per transition; outputs are registered and change on the clk where the edge is detected:
  - IDLE --accept--> W_ADDR.
  - W_ADDR --rise[PH_ADDR]--> drive Addr_A and Addr_B. Write goes to W_DATA; read goes to W_EN.
  - W_DATA --rise[PH_DATA]--> drive din, then W_EN.
  - W_EN --rise[PH_EN]--> write: RegWrtBar = 1, then W_WE. Read: ReadEn = 1, then R_END.
  - W_WE --rise[PH_WE]--> WriteEn = 1, then W_WEEND.
  - W_WEEND --rise[PH_WE_END]--> WriteEn = 0, then W_RWB.
  - W_RWB --fall[PH_EN]--> RegWrtBar = 0, rsp_valid = 1, rsp_write = 1, then IDLE.
  - R_END --rise[PH_WE]--> ReadEn = 0, capture outA/outB into rsp_data_a/b, rsp_valid = 1, rsp_write = 0, then IDLE.
- Acceptance after rise[PH_ADDR] of the current Bennett cycle: the transaction waits for the next cycle's rise. No phase is ever skipped.
- Addr_A, Addr_B and din hold their values after completion until the next transaction overwrites them.
- rsp_data_a/b change only on read completion.
- Back-to-back requests: the next request is accepted the clk after rsp_valid. It starts at the next rise[PH_ADDR].
- Simultaneous rise and fall on the same clk: only the edge the current state waits on is acted upon.
- Reset mid-operation: ReadEn, WriteEn and RegWrtBar drop immediately (asynchronously). The transaction is dropped and no rsp_valid is produced.
- At most one of ReadEn and WriteEn is high at any time. WriteEn is high only while RegWrtBar is high.

Test Plan:
- Write addr_a = 5'h1F, wdata = 16'hAAAA.
  - Addr_A = 1F at rise[2]; din = AAAA at rise[4]; RegWrtBar rises at rise[6].
  - WriteEn is high from rise[8] to rise[9]; RegWrtBar falls at fall[6].
  - rsp_valid with rsp_write = 1.
- Read addr_a = addr_b = 5'h1F after that write, with the bank model holding AAAA:
  - ReadEn is high from rise[6] to rise[8].
  - rsp_data_a = rsp_data_b = 16'hAAAA; WriteEn stays 0.
- Read addr_a = 5'h03 with bank value 16'h0000:
  - rsp_data_a = 0, and rsp_data_b retains its prior value only if addr_b is unchanged.
- Request accepted between rise[2] and rise[4]:
  - Addr_A does not change until the next cycle's rise[2].
  - Total latency is 1 Bennett cycle plus the remaining phases.
- Reset asserted while WriteEn = 1:
  - WriteEn, RegWrtBar and ReadEn go to 0 in the same timestep, and no rsp_valid occurs.
  - After release, req_ready = 1 and the clkpos already high at release causes no action.
- Two queued reads (req_valid held high):
  - Second acceptance occurs the clk after the first rsp_valid.
  - The second transaction completes exactly one Bennett cycle later.

Source files
------------

// File: rtl/sram_bank_sequencer.sv
// Host-side initiator for the two-port SRAM bank: turns single valid/ready
// requests into address/data/enable strobes aligned to Bennett phase edges.
module sram_bank_sequencer #(
    parameter int WIDTH     = 10,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 16,
    parameter int PH_ADDR   = 2,
    parameter int PH_DATA   = 4,
    parameter int PH_EN     = 6,
    parameter int PH_WE     = 8,
    parameter int PH_WE_END = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  clkpos,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic [ADDR_W-1:0] Addr_A,
    output logic [ADDR_W-1:0] Addr_B,
    output logic [DATA_W-1:0] din,
    output logic              ReadEn,
    output logic              RegWrtBar,
    output logic              WriteEn,
    input  logic [DATA_W-1:0] outA,
    input  logic [DATA_W-1:0] outB
);

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        W_EN,
        W_WE,
        W_WEEND,
        W_RWB,
        R_END
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  clkpos_q;
    logic              armed;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic              unused_edges;

    logic              write_q;
    logic [ADDR_W-1:0] addr_a_q;
    logic [ADDR_W-1:0] addr_b_q;
    logic [DATA_W-1:0] wdata_q;

    // armed masks the first clk after reset so phases already high are not edges
    assign rise = clkpos & ~clkpos_q & {WIDTH{armed}};
    assign fall = ~clkpos & clkpos_q & {WIDTH{armed}};
    assign unused_edges = ^{rise, fall};

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clkpos_q   <= '0;
            armed      <= 1'b0;
            write_q    <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            wdata_q    <= '0;
            Addr_A     <= '0;
            Addr_B     <= '0;
            din        <= '0;
            ReadEn     <= 1'b0;
            RegWrtBar  <= 1'b0;
            WriteEn    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_data_a <= '0;
            rsp_data_b <= '0;
        end else begin
            armed     <= 1'b1;
            clkpos_q  <= clkpos;
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        addr_a_q <= req_addr_a;
                        addr_b_q <= req_addr_b;
                        wdata_q  <= req_wdata;
                        state    <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (rise[PH_ADDR]) begin
                        Addr_A <= addr_a_q;
                        Addr_B <= addr_b_q;
                        state  <= write_q ? W_DATA : W_EN;
                    end
                end
                W_DATA: begin
                    if (rise[PH_DATA]) begin
                        din   <= wdata_q;
                        state <= W_EN;
                    end
                end
                W_EN: begin
                    if (rise[PH_EN]) begin
                        if (write_q) begin
                            RegWrtBar <= 1'b1;
                            state     <= W_WE;
                        end else begin
                            ReadEn <= 1'b1;
                            state  <= R_END;
                        end
                    end
                end
                W_WE: begin
                    if (rise[PH_WE]) begin
                        WriteEn <= 1'b1;
                        state   <= W_WEEND;
                    end
                end
                W_WEEND: begin
                    if (rise[PH_WE_END]) begin
                        WriteEn <= 1'b0;
                        state   <= W_RWB;
                    end
                end
                // RegWrtBar is held until its own phase falls, bracketing WriteEn
                W_RWB: begin
                    if (fall[PH_EN]) begin
                        RegWrtBar <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        state     <= IDLE;
                    end
                end
                R_END: begin
                    if (rise[PH_WE]) begin
                        ReadEn     <= 1'b0;
                        rsp_data_a <= outA;
                        rsp_data_b <= outB;
                        rsp_valid  <= 1'b1;
                        rsp_write  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
